// File: rtl/ddr3_cpu_req_frontend.sv
// ---------------------------------------------------------------------------
// ddr3_cpu_req_frontend
//   Host-side request front end of the DDR3 controller. CPU read/write
//   requests are accepted with a valid/ready handshake, queued in a small
//   FIFO and presented to the command engine, which pops the head with
//   i_req_ack. Read data coming back from the engine is registered and
//   returned to the CPU in request order.
//
// Handshake rules:
//   CPU side    : a request transfers on a rising edge where i_cpu_valid and
//                 o_cpu_data_rdy are both high. After every transfer ready
//                 is low for one cycle, so a CPU that keeps valid asserted
//                 until it sees ready drop transfers exactly once.
//   Engine side : o_req_valid marks a valid head; i_req_ack pops it on the
//                 rising edge. An ack while the FIFO is empty is ignored.
//
// Ports:
//   i_cpu_ck, i_cpu_reset             clock, synchronous active-high reset
//   i_cpu_valid/cmd/addr/wr_data      CPU request (cmd 1 = write, 0 = read)
//   o_cpu_data_rdy                    request can be accepted this cycle
//   o_cpu_rd_data(_valid)             read data to CPU, one-cycle pulse
//   o_req_valid/cmd/addr/wr_data      FIFO head toward the command engine
//   i_req_ack                         engine pops FIFO head
//   i_rd_data(_valid)                 read data from engine/PHY
//   o_err_unexp_rd                    sticky: read data with none outstanding
// ---------------------------------------------------------------------------
module ddr3_cpu_req_frontend #(
    parameter int ADDR_W      = 27,
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 4,
    parameter int MAX_RD      = 4,
    parameter int INIT_CYCLES = 5000
) (
    input  logic              i_cpu_ck,
    input  logic              i_cpu_reset,
    input  logic              i_cpu_valid,
    input  logic              i_cpu_cmd,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wr_data,
    output logic              o_cpu_data_rdy,
    output logic [DATA_W-1:0] o_cpu_rd_data,
    output logic              o_cpu_rd_data_valid,
    output logic              o_req_valid,
    output logic              o_req_cmd,
    output logic [ADDR_W-1:0] o_req_addr,
    output logic [DATA_W-1:0] o_req_wr_data,
    input  logic              i_req_ack,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_rd_data_valid,
    output logic              o_err_unexp_rd
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RD_W   = $clog2(MAX_RD + 1);
    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int ENT_W  = 1 + ADDR_W + DATA_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [INIT_W-1:0]  init_cnt;
    logic [CNT_W-1:0]   count, count_d;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [RD_W-1:0]    rd_out, rd_out_d;
    logic [ENT_W-1:0]   mem [DEPTH];

    logic accept, push, pop, rd_inc, rd_dec, rdy_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake and bookkeeping events for this edge.
    assign accept = i_cpu_valid & o_cpu_data_rdy;
    assign push   = accept;
    assign pop    = i_req_ack & (count != '0);
    assign rd_inc = accept & ~i_cpu_cmd;
    // rd_out is always zero during INIT, so early returns are dropped here too.
    assign rd_dec = i_rd_data_valid & (rd_out != '0);

    // FSM next state: leave INIT once the init window has elapsed.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
            state_d = ST_RUN;
        end
    end

    // Next-cycle FIFO occupancy, outstanding reads and ready.
    always_comb begin
        count_d  = count;
        rd_out_d = rd_out;
        case ({push, pop})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
        case ({rd_inc, rd_dec})
            2'b10:   rd_out_d = rd_out + RD_W'(1);
            2'b01:   rd_out_d = rd_out - RD_W'(1);
            default: rd_out_d = rd_out;
        endcase
        // Ready is registered, so it is derived from the post-edge values.
        // The !accept term blanks ready for the cycle after each transfer.
        rdy_d = (state_d == ST_RUN) && (count_d < CNT_W'(DEPTH)) &&
                (rd_out_d < RD_W'(MAX_RD)) && !accept;
    end

    always_ff @(posedge i_cpu_ck) begin
        if (i_cpu_reset) begin
            state_q             <= ST_INIT;
            init_cnt            <= '0;
            count               <= '0;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            rd_out              <= '0;
            o_cpu_data_rdy      <= 1'b0;
            o_cpu_rd_data       <= '0;
            o_cpu_rd_data_valid <= 1'b0;
            o_err_unexp_rd      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT && state_d == ST_INIT) begin
                init_cnt <= init_cnt + INIT_W'(1);
            end
            count          <= count_d;
            rd_out         <= rd_out_d;
            o_cpu_data_rdy <= rdy_d;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            o_cpu_rd_data_valid <= rd_dec;
            if (rd_dec) o_cpu_rd_data <= i_rd_data;
            if (state_q == ST_RUN && i_rd_data_valid && rd_out == '0) begin
                o_err_unexp_rd <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted valid.
    always_ff @(posedge i_cpu_ck) begin
        if (push) mem[wr_ptr] <= {i_cpu_cmd, i_cpu_addr, i_cpu_wr_data};
    end

    // Head fields read straight from storage; forced to zero while empty.
    assign o_req_valid = (count != '0);
    assign {o_req_cmd, o_req_addr, o_req_wr_data} = o_req_valid ? mem[rd_ptr] : '0;

endmodule
